serial_in_scanner: RTL

//  Controller/deserializer for the board's 74LV165 parallel-in/serial-out chains (panel switches -> FPGA).

---
 rtl/serial_pkg.sv | 35 +++
 rtl/serial_phase_timer.sv | 30 +++
 rtl/serial_in_scanner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the 74LV165 panel-switch scanner.
// Also holds the field map used to decode the scanned panel word.
package serial_pkg;

  localparam int DEF_NUM_CHAINS  = 5;
  localparam int DEF_CHAIN_BITS  = 16;
  localparam int DEF_HALF_PERIOD = 2;
  localparam int PANEL_BITS      = DEF_NUM_CHAINS * DEF_CHAIN_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [30:0] arr_reg_c;
    logic [11:0] arr_strt;
    logic [11:0] arr_sel;
    logic [11:0] arr_cmp;
  } panel_fields_t;

  // chains 1:0 -> {1'b0, reg_c}; chains 3:2 -> {8'b0, strt, sel}; chain 4 -> {4'b0, cmp}
  function automatic panel_fields_t decode_panel(input logic [PANEL_BITS-1:0] word);
    panel_fields_t f;
    f.arr_reg_c = word[30:0];
    f.arr_sel   = word[43:32];
    f.arr_strt  = word[55:44];
    f.arr_cmp   = word[75:64];
    return f;
  endfunction

endpackage

// File: rtl/serial_phase_timer.sv
// Down-counter that times one shift-clock phase of HALF_PERIOD clk cycles.
// phase_end is high in the last cycle of a phase; restart begins a new phase next cycle.
module serial_phase_timer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/serial_in_scanner.sv
// Controller/deserializer for 74LV165 PISO chains: load, clock out MSB first,
// and present one parallel word per chain with a single-cycle data_val strobe.
module serial_in_scanner
  import serial_pkg::*;
#(
  parameter int NUM_CHAINS  = DEF_NUM_CHAINS,
  parameter int CHAIN_BITS  = DEF_CHAIN_BITS,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             scan_start,
  input  logic                             auto_scan,
  output logic                             serial_in_rclk,
  output logic                             serial_in_shldn,
  input  logic [NUM_CHAINS-1:0]            serial_in_ser,
  output logic [NUM_CHAINS*CHAIN_BITS-1:0] data_out,
  output logic                             data_val,
  output logic                             busy
);

  localparam int BW = $clog2(CHAIN_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_BITS - 1);

  scan_state_t           state;
  scan_state_t           next_state;
  logic [NUM_CHAINS-1:0] ser_q;
  logic [BW-1:0]         bit_cnt;
  logic                  phase_end;
  logic                  restart;
  logic                  sample;
  logic                  last_sample;

  serial_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .phase_end(phase_end)
  );

  // Pins are registered from next_state so they are glitch-free and track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ser_q           <= '0;
      serial_in_rclk  <= 1'b0;
      serial_in_shldn <= 1'b1;
    end else begin
      state           <= next_state;
      ser_q           <= serial_in_ser;
      serial_in_rclk  <= (next_state == HIGH);
      serial_in_shldn <= (next_state != LOAD);
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    data_val    = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_start || auto_scan) next_state = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (phase_end) next_state = LOW;
      end
      LOW: begin
        busy = 1'b1;
        if (phase_end) begin
          sample      = 1'b1;
          last_sample = (bit_cnt == LAST_BIT);
          next_state  = last_sample ? DONE : HIGH;
        end
      end
      HIGH: begin
        busy = 1'b1;
        if (phase_end) next_state = LOW;
      end
      DONE: begin
        data_val   = 1'b1;
        next_state = (scan_start || auto_scan) ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign restart = (next_state != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (restart && next_state == LOAD) begin
      bit_cnt <= '0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    logic [CHAIN_BITS-1:0] shift_q;
    logic [CHAIN_BITS-1:0] word_q;
    logic [CHAIN_BITS-1:0] shift_d;

    assign shift_d = {shift_q[CHAIN_BITS-2:0], ser_q[c]};

    // NOTE: shift_q is deliberately not reset; each scan rewrites all of it before it reaches word_q.
    always_ff @(posedge clk) begin
      if (sample) shift_q <= shift_d;
    end

    // The final sample goes straight into word_q so data_out is new during the DONE cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        word_q <= '0;
      end else if (last_sample) begin
        word_q <= shift_d;
      end
    end

    assign data_out[c*CHAIN_BITS +: CHAIN_BITS] = word_q;
  end

endmodule
